tdm_mux_8to1: RTL and testbench
===============================

Name: tdm_mux_8to1

Overview:
- Sequential 8-to-1 time-division multiplexer. It is the transmit end feeding a downstream demux_1to8.
- Accepts an 8-bit parallel word via a valid/ready handshake, then serialises it one slot at a time onto `y`.
- Drives the 3-bit slot index `s` alongside `y`, so a 1-to-8 demultiplexer can route each bit back to lane `s`.
- Sits between the parallel data source and the shared serial link.

Parameters:
- SLOT_CYCLES, 1: clock cycles each slot is held on `y`/`s` (legal range 1..16).
- SLOT_CNT_W, 4: width of the internal slot-hold counter; must satisfy 2^SLOT_CNT_W >= SLOT_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- d  input  8  parallel word; bit k is transmitted in slot k.
- in_valid  input  1  source offers `d`.
- in_ready  output  1  block can accept `d` this cycle.
- i  output  1  link-enable strobe for the downstream demux `i` input; equals out_valid.
- y  output  1  serial data bit for the current slot.
- s  output  3  current slot index (downstream demux select).
- out_valid  output  1  `y`/`s` carry a live slot.
- frame_start  output  1  high for the first cycle of slot 0 of each word.
- par_slot  output  1  high during the parity slot (see Optional Feature); 0 otherwise.

Behaviour:
- Reset (rst_n=0, asynchronous) forces the following, independent of clk:
  - state=IDLE, word register=0, s=0, slot counter=0.
  - y=0, out_valid=0, i=0, frame_start=0, par_slot=0.
  - in_ready=0 while rst_n=0; in_ready=1 from the first edge after release.
- Reset asserted mid-frame aborts the frame immediately, with no further slots driven. The word in progress is discarded.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid&in_ready at edge T: capture `d` into the word register and go to SEND with s=0.
  - SEND: out_valid=1 from T+1. in_ready=0 except in the final cycle of the final slot.
    - Each slot lasts SLOT_CYCLES cycles, then s increments.
    - After the last cycle of slot 7, go to IDLE, or restart SEND if a new word is accepted.
- Outputs in SEND:
  - y = word[s], registered (output flops, no combinational path from `d` to `y`).
  - frame_start=1 only in the first cycle of slot 0.
- Latency: the first bit appears on `y` exactly 1 cycle after the accepting edge. One frame is 8*SLOT_CYCLES cycles.
- Back-to-back transfers:
  - in_ready is high during the final cycle of slot 7.
  - If in_valid is high in that cycle, the next word is captured and slot 0 of the new word follows with zero idle cycles.
  - frame_start pulses again for the new word.
- Stability:
  - `d` changing during SEND has no effect; only the captured word is sent.
  - in_valid held low in IDLE leaves outputs idle indefinitely.
- s wrap-around: s is a 3-bit counter. 7 -> 0 only on a new frame. In IDLE, s holds 0.
- The handshake obeys standard valid/ready rules. A transfer occurs only when both are high on the same edge, and in_ready does not depend combinationally on in_valid.

Optional Feature:
- Macro TDM_MUX_PARITY_EN.
- Defined:
  - A ninth slot follows slot 7, lasting SLOT_CYCLES cycles.
  - In it: y = even parity of the word (XOR of d[7:0]), s=0, par_slot=1, out_valid=1.
  - The frame is 9*SLOT_CYCLES cycles.
  - in_ready asserts in the final cycle of the parity slot instead of slot 7.
- Undefined: no parity slot; par_slot tied 0; frame is 8*SLOT_CYCLES cycles.

Test Plan:
- Reset: hold rst_n=0 mid-frame, then release → all outputs 0 asynchronously; first post-reset edge gives in_ready=1, out_valid=0.
- Single word, SLOT_CYCLES=1: d=8'hA5, one-cycle in_valid → next 8 cycles y=1,0,1,0,0,1,0,1 with s=0..7; frame_start only with s=0; then out_valid=0 and in_ready=1.
- Hold stretching, SLOT_CYCLES=3: d=8'h0F → each s value held 3 cycles; y=1 for s=0..3 and y=0 for s=4..7; 24 valid cycles total.
- Back-to-back: d=8'hFF then 8'h00 with in_valid continuously high → 16 consecutive out_valid cycles with no gap; frame_start at cycle 1 and cycle 9; `d` changes mid-frame are ignored.
- Loopback: connect `i`/`s`/`y` to a demux_1to8 (y_demux[s] captured per slot), send 8'h3C → reassembled lane pattern equals 8'h3C.
- With TDM_MUX_PARITY_EN: d=8'h07 → slots 0..7 as data, ninth slot y=1 (odd count of ones), par_slot=1, s=0; in_ready rises only in the ninth slot.

Source files
------------

// File: rtl/tdm_mux_8to1_if.sv
// Parallel-in / serial-out link bundle for tdm_mux_8to1.
// The master side supplies the word; the slave side (the mux) drives the slot outputs.
interface tdm_mux_8to1_if;
  logic [7:0] d;
  logic       in_valid;
  logic       in_ready;
  logic       i;
  logic       y;
  logic [2:0] s;
  logic       out_valid;
  logic       frame_start;
  logic       par_slot;

  modport master (
    output d, in_valid,
    input  in_ready, i, y, s, out_valid, frame_start, par_slot
  );

  modport slave (
    input  d, in_valid,
    output in_ready, i, y, s, out_valid, frame_start, par_slot
  );
endinterface

// File: rtl/tdm_mux_8to1.sv
// Sequential 8-to-1 TDM serialiser feeding a downstream 1-to-8 demux.
// Defining TDM_MUX_PARITY_EN appends an even-parity slot after slot 7.
module tdm_mux_8to1 #(
  parameter int SLOT_CYCLES = 1,
  parameter int SLOT_CNT_W  = 4
) (
  input logic           clk,
  input logic           rst_n,
  tdm_mux_8to1_if.slave bus
);
  // state | meaning
  // IDLE  | no frame in flight; in_ready high once out of reset
  // SEND  | word[s] on y, each slot held SLOT_CYCLES cycles
  // PAR   | parity slot after slot 7 (parity build only)
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, PAR = 2'd2} state_t;

  localparam logic [SLOT_CNT_W-1:0] CNT_LOAD = SLOT_CNT_W'(SLOT_CYCLES - 1);
  localparam logic [SLOT_CNT_W-1:0] CNT_ONE  = SLOT_CNT_W'(1);

  state_t                state, state_nxt;
  logic [7:0]            word, word_nxt;
  logic [2:0]            s_q, s_nxt, s_inc;
  logic [SLOT_CNT_W-1:0] cnt, cnt_nxt;
  logic                  y_q, y_nxt;
  logic                  fs_q, fs_nxt;
  logic                  live;
  logic                  slot_end, frame_end, ready, accept;

  assign s_inc    = s_q + 3'd1;
  assign slot_end = (cnt == '0);
`ifdef TDM_MUX_PARITY_EN
  assign frame_end = (state == PAR) && slot_end;
`else
  assign frame_end = (state == SEND) && slot_end && (s_q == 3'd7);
`endif
  // live keeps in_ready low until the first edge after reset release
  assign ready  = live && ((state == IDLE) || frame_end);
  assign accept = ready && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      word  <= '0;
      s_q   <= '0;
      cnt   <= '0;
      y_q   <= 1'b0;
      fs_q  <= 1'b0;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      word  <= word_nxt;
      s_q   <= s_nxt;
      cnt   <= cnt_nxt;
      y_q   <= y_nxt;
      fs_q  <= fs_nxt;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = SEND;
    end else begin
      case (state)
        SEND: begin
          if (slot_end && (s_q == 3'd7)) begin
`ifdef TDM_MUX_PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = IDLE;
`endif
          end
        end
        PAR:     if (slot_end) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // y is loaded one cycle ahead so the pin is a flop output
  always_comb begin
    word_nxt = word;
    s_nxt    = s_q;
    cnt_nxt  = cnt;
    y_nxt    = y_q;
    fs_nxt   = 1'b0;
    if (accept) begin
      word_nxt = bus.d;
      s_nxt    = 3'd0;
      cnt_nxt  = CNT_LOAD;
      y_nxt    = bus.d[0];
      fs_nxt   = 1'b1;
    end else if (state_nxt == IDLE) begin
      s_nxt   = 3'd0;
      cnt_nxt = '0;
      y_nxt   = 1'b0;
    end else if (!slot_end) begin
      cnt_nxt = cnt - CNT_ONE;
    end else if (state_nxt == PAR) begin
      s_nxt   = 3'd0;
      cnt_nxt = CNT_LOAD;
      y_nxt   = ^word;
    end else begin
      s_nxt   = s_inc;
      cnt_nxt = CNT_LOAD;
      y_nxt   = word[s_inc];
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = (state != IDLE);
  assign bus.i           = (state != IDLE);
  assign bus.y           = y_q;
  assign bus.s           = s_q;
  assign bus.frame_start = fs_q;
`ifdef TDM_MUX_PARITY_EN
  assign bus.par_slot    = (state == PAR);
`else
  assign bus.par_slot    = 1'b0;
`endif
endmodule

// File: tb/tb_tdm_mux_8to1.sv
// Self-checking bench: two muxes (1 and 3 cycles per slot) against a frame-queue model.
// Honours TDM_MUX_PARITY_EN the same way as the design.
module tb_tdm_mux_8to1;
  localparam int SC_F = 1;
  localparam int SC_S = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d_drv;
  logic       v_drv;

  tdm_mux_8to1_if bus_f ();
  tdm_mux_8to1_if bus_s ();

  assign bus_f.d        = d_drv;
  assign bus_f.in_valid = v_drv;
  assign bus_s.d        = d_drv;
  assign bus_s.in_valid = v_drv;

  tdm_mux_8to1 #(.SLOT_CYCLES(SC_F), .SLOT_CNT_W(4)) u_fast (.clk(clk), .rst_n(rst_n), .bus(bus_f));
  tdm_mux_8to1 #(.SLOT_CYCLES(SC_S), .SLOT_CNT_W(4)) u_slow (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       y;
    logic [2:0] s;
    logic       fs;
    logic       par;
  } slot_t;

  slot_t      q_f[$];
  slot_t      q_s[$];
  logic       live_m [2];
  logic       acc    [2];
  logic [7:0] lanes  [2];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input int u, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s unit%0d: observed=%0h expected=%0h", tag, u, obs, exp);
    end
  endtask

  // Expected slot sequence of one frame, straight from the slot rules
  task automatic push_frame(input int u, input logic [7:0] w);
    int    sc;
    slot_t e;
    sc = (u == 0) ? SC_F : SC_S;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < sc; c++) begin
        e.y   = w[k];
        e.s   = 3'(k);
        e.fs  = (k == 0) && (c == 0);
        e.par = 1'b0;
        if (u == 0) q_f.push_back(e); else q_s.push_back(e);
      end
    end
`ifdef TDM_MUX_PARITY_EN
    for (int c = 0; c < sc; c++) begin
      e.y   = ^w;
      e.s   = 3'd0;
      e.fs  = 1'b0;
      e.par = 1'b1;
      if (u == 0) q_f.push_back(e); else q_s.push_back(e);
    end
`endif
  endtask

  task automatic chk_unit(input int u);
    logic       ov, rdy, y, iv, fs, par, exp_rdy;
    logic [2:0] s;
    slot_t      e;
    int         n;
    if (u == 0) begin
      ov = bus_f.out_valid; rdy = bus_f.in_ready; y = bus_f.y; iv = bus_f.i;
      fs = bus_f.frame_start; par = bus_f.par_slot; s = bus_f.s; n = q_f.size();
      e = (n > 0) ? q_f[0] : '0;
    end else begin
      ov = bus_s.out_valid; rdy = bus_s.in_ready; y = bus_s.y; iv = bus_s.i;
      fs = bus_s.frame_start; par = bus_s.par_slot; s = bus_s.s; n = q_s.size();
      e = (n > 0) ? q_s[0] : '0;
    end
    exp_rdy = live_m[u] && (n <= 1);
    chk("in_ready",    u, 8'(rdy), 8'(exp_rdy));
    chk("out_valid",   u, 8'(ov),  8'(n > 0));
    chk("i",           u, 8'(iv),  8'(n > 0));
    chk("y",           u, 8'(y),   8'(e.y));
    chk("s",           u, 8'(s),   8'(e.s));
    chk("frame_start", u, 8'(fs),  8'(e.fs));
    chk("par_slot",    u, 8'(par), 8'(e.par));
    acc[u] = v_drv && exp_rdy;
    if (iv && !par) lanes[u][s] = y;
  endtask

  task automatic adv_unit(input int u);
    if (u == 0) begin
      if (q_f.size() > 0) void'(q_f.pop_front());
    end else begin
      if (q_s.size() > 0) void'(q_s.pop_front());
    end
    if (acc[u]) push_frame(u, d_drv);
    live_m[u] = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    chk_unit(0);
    chk_unit(1);
    @(posedge clk);
    if (rst_n) begin
      adv_unit(0);
      adv_unit(1);
    end
    #1;
  endtask

  task automatic clear_model();
    q_f.delete();
    q_s.delete();
    for (int u = 0; u < 2; u++) begin
      live_m[u] = 1'b0;
      acc[u]    = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v_drv = 1'b0;
    d_drv = 8'h00;
    clear_model();
    lanes[0] = 8'h00;
    lanes[1] = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();

    // single word A5
    d_drv = 8'hA5; v_drv = 1'b1; tick(); v_drv = 1'b0;
    repeat (30) begin d_drv = 8'($urandom); tick(); end

    // 0F, slot hold visible on the slow unit
    d_drv = 8'h0F; v_drv = 1'b1; tick(); v_drv = 1'b0;
    repeat (30) begin d_drv = 8'($urandom); tick(); end

    // back-to-back: FF then 00 with in_valid held high
    d_drv = 8'hFF; v_drv = 1'b1; tick();
    d_drv = 8'h00;
    repeat (60) tick();
    v_drv = 1'b0;
    repeat (32) tick();

    // loopback through a demux: lanes[s] <= y while i is high
    lanes[0] = 8'h00;
    lanes[1] = 8'h00;
    d_drv = 8'h3C; v_drv = 1'b1; tick(); v_drv = 1'b0;
    repeat (30) begin d_drv = 8'($urandom); tick(); end
    chk("loopback", 0, lanes[0], 8'h3C);
    chk("loopback", 1, lanes[1], 8'h3C);

    // reset asserted mid-frame, between clock edges
    d_drv = 8'($urandom); v_drv = 1'b1; tick(); v_drv = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    chk_unit(0);
    chk_unit(1);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // random traffic
    repeat (400) begin
      v_drv = ($urandom_range(0, 3) != 0);
      d_drv = 8'($urandom);
      tick();
    end
    v_drv = 1'b0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
